dino_score_ctrl: RTL and testbench
==================================

DINO_SCORE_CTRL -- requirements
Module: dino_score_ctrl

Interface
REQ-001 Parameter FRAMES_PER_POINT, default 6: frame ticks per score point, legal range 1..15.
REQ-002 Parameter SPEEDUP_POINTS, default 100: points per speed level, legal values 10, 100, 1000.
REQ-003 clk  input  1  single design clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 ena  input  1  design enable; low = all state frozen.
REQ-006 start  input  1  one-cycle pulse, begins a game.
REQ-007 frame_tick  input  1  one-cycle pulse per display frame.
REQ-008 collide  input  1  one-cycle pulse, dino hit obstacle.
REQ-009 state  output  2  game state: 0 IDLE, 1 RUN, 2 OVER.
REQ-010 score_bcd  output  16  current score, 4 BCD digits, digit 3 = MSD.
REQ-011 hi_bcd  output  16  high score, 4 BCD digits.
REQ-012 speed  output  3  speed level for obstacle scroller.
REQ-013 new_hi  output  1  high when last game set a new high score.

Function
REQ-014 FSM states IDLE, RUN, OVER; transitions on the clock edge where the qualifying input is sampled high.
REQ-015 IDLE + start -> RUN; score_bcd, speed, frame counter cleared on the same edge.
REQ-016 RUN + collide -> OVER; start ignored in RUN.
REQ-017 OVER + start -> RUN; score_bcd, speed, frame counter, new_hi cleared; hi_bcd kept.
REQ-018 IDLE/OVER: frame_tick and collide ignored; score_bcd held.
REQ-019 RUN: each frame_tick increments a 4-bit frame counter; at FRAMES_PER_POINT-1 the counter wraps to 0 and score_bcd increments by 1 (BCD) on the same edge.
REQ-020 Score visible one cycle after the completing frame_tick (latency 1).
REQ-021 BCD increment: each digit 0..9, carry ripples across digits; no digit ever holds A..F.
REQ-022 score_bcd saturates at 9999; further points leave it at 9999, no wrap.
REQ-023 speed increments by 1 when the score becomes a nonzero multiple of SPEEDUP_POINTS; saturates at 7.
REQ-024 collide and frame_tick on the same RUN cycle: collide wins, no score increment, -> OVER.
REQ-025 On the RUN->OVER edge: if score_bcd > hi_bcd (unsigned compare of the BCD values), hi_bcd <= score_bcd and new_hi <= 1; else both unchanged.
REQ-026 Equal score does not set new_hi.
REQ-027 ena low: state, counters, and outputs hold; inputs ignored that cycle.
REQ-028 All outputs are registered; no combinational path from inputs to outputs.

Reset
REQ-029 rst_n low asynchronously forces state=IDLE, score_bcd=0, hi_bcd=0, speed=0, new_hi=0, frame counter=0.
REQ-030 Reset mid-game discards score and hi_bcd; first edge after deassertion behaves as IDLE.
REQ-031 Reset deassertion is synchronized externally; the block does not synchronize it.

Structure
REQ-032 Shared package dino_pkg holds: the game-state enum (IDLE/RUN/OVER encodings), the BCD-digit and 4-digit-score typedefs, and default values for FRAMES_PER_POINT/SPEEDUP_POINTS.
REQ-033 One combinational sub-module bcd_inc4: 16-bit BCD in -> BCD+1 out, saturating at 9999, plus a flag for a nonzero multiple of 10/100/1000.
REQ-034 FSM, frame counter, speed logic, and high-score compare reside in dino_score_ctrl.

Verification
REQ-035 Reset, then start, then 12 frame_ticks (FRAMES_PER_POINT=6) -> state=1, score_bcd=0x0002 one cycle after the 12th tick.
REQ-036 Preload score 0x0099, complete one point -> score_bcd=0x0100, speed=1; at 0x0009 -> 0x0010, speed unchanged.
REQ-037 Run to 0x9999, 30 more ticks -> score_bcd stays 0x9999, speed=7.
REQ-038 Score 0x0042, hi 0x0000, collide with frame_tick same cycle -> state=2, score 0x0042, hi_bcd=0x0042, new_hi=1; start -> state=1, score 0, new_hi=0, hi 0x0042.
REQ-039 Second game ends at 0x0042 (equal) -> hi_bcd=0x0042, new_hi=0; ena held low across 10 ticks in RUN -> score unchanged.
REQ-040 Assert rst_n low mid-RUN between clock edges -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/dino_pkg.sv
// rtl/dino_pkg.sv - shared types and defaults for the dino score controller
package dino_pkg;

    typedef enum logic [1:0] {
        GS_IDLE = 2'd0,
        GS_RUN  = 2'd1,
        GS_OVER = 2'd2
    } game_state_e;

    localparam logic [1:0] ST_IDLE = GS_IDLE;
    localparam logic [1:0] ST_RUN  = GS_RUN;
    localparam logic [1:0] ST_OVER = GS_OVER;

    typedef logic [3:0] bcd_digit_t;
    typedef bcd_digit_t [3:0] bcd_score_t;

    localparam int DEF_FRAMES_PER_POINT = 6;
    localparam int DEF_SPEEDUP_POINTS   = 100;

    localparam logic [2:0] SPEED_MAX = 3'd7;

endpackage

// File: rtl/bcd_inc4.sv
// rtl/bcd_inc4.sv - saturating 4-digit BCD incrementer with decade flags
module bcd_inc4
    import dino_pkg::*;
(
    input  logic [15:0] bcd_in,
    output logic [15:0] bcd_out,
    output logic        mult10,
    output logic        mult100,
    output logic        mult1000
);

    bcd_score_t in_digits;
    bcd_score_t out_digits;
    logic       carry;

    assign in_digits = bcd_in;
    assign bcd_out   = out_digits;

    // Ripple a +1 through the digits; 9999 is held rather than wrapping to 0000
    always_comb begin
        out_digits = in_digits;
        carry      = 1'b1;
        if (bcd_in != 16'h9999) begin
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (in_digits[i] == 4'd9) begin
                        out_digits[i] = 4'd0;
                    end else begin
                        out_digits[i] = in_digits[i] + 4'd1;
                        carry         = 1'b0;
                    end
                end
            end
        end
    end

    // Flag results that land on a nonzero multiple of each decade
    always_comb begin
        mult10   = (bcd_out[3:0]  == 4'h0)  && (bcd_out != 16'h0000);
        mult100  = (bcd_out[7:0]  == 8'h00) && (bcd_out != 16'h0000);
        mult1000 = (bcd_out[11:0] == 12'h000) && (bcd_out != 16'h0000);
    end

endmodule

// File: rtl/dino_score_ctrl.sv
// rtl/dino_score_ctrl.sv - dino game FSM, frame-to-point counter, speed and high score
module dino_score_ctrl
    import dino_pkg::*;
#(
    parameter int FRAMES_PER_POINT = DEF_FRAMES_PER_POINT,
    parameter int SPEEDUP_POINTS   = DEF_SPEEDUP_POINTS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic        start,
    input  logic        frame_tick,
    input  logic        collide,
    output logic [1:0]  state,
    output logic [15:0] score_bcd,
    output logic [15:0] hi_bcd,
    output logic [2:0]  speed,
    output logic        new_hi
);

    localparam logic [3:0] FCNT_LAST = 4'(FRAMES_PER_POINT - 1);

    logic [3:0]  fcnt;
    logic [15:0] score_next;
    logic        m10;
    logic        m100;
    logic        m1000;
    logic        speed_hit;

    bcd_inc4 u_inc (
        .bcd_in   (score_bcd),
        .bcd_out  (score_next),
        .mult10   (m10),
        .mult100  (m100),
        .mult1000 (m1000)
    );

    // Pick the decade flag that matches the configured speed-up interval
    always_comb begin
        speed_hit = m100;
        if (SPEEDUP_POINTS == 10) begin
            speed_hit = m10;
        end else if (SPEEDUP_POINTS == 1000) begin
            speed_hit = m1000;
        end
    end

    // Game FSM with score, speed and high-score bookkeeping; ena low freezes everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            score_bcd <= 16'h0000;
            hi_bcd    <= 16'h0000;
            speed     <= 3'd0;
            new_hi    <= 1'b0;
            fcnt      <= 4'd0;
        end else if (ena) begin
            case (state)
                ST_IDLE, ST_OVER: begin
                    if (start) begin
                        state     <= ST_RUN;
                        score_bcd <= 16'h0000;
                        speed     <= 3'd0;
                        fcnt      <= 4'd0;
                        new_hi    <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (collide) begin
                        state <= ST_OVER;
                        // BCD digits order the same way as binary, so a plain compare works
                        if (score_bcd > hi_bcd) begin
                            hi_bcd <= score_bcd;
                            new_hi <= 1'b1;
                        end
                    end else if (frame_tick) begin
                        if (fcnt == FCNT_LAST) begin
                            fcnt      <= 4'd0;
                            score_bcd <= score_next;
                            if (speed_hit && (speed != SPEED_MAX)) begin
                                speed <= speed + 3'd1;
                            end
                        end else begin
                            fcnt <= fcnt + 4'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dino_score_ctrl.sv
// tb/tb_dino_score_ctrl.sv - directed self-checking bench for dino_score_ctrl
module tb_dino_score_ctrl;

    typedef struct {
        logic        ena;
        logic        start;
        logic        ft;
        logic        col;
        logic [1:0]  st;
        logic [15:0] sc;
        logic [15:0] hi;
        logic [2:0]  sp;
        logic        nh;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic        start;
    logic        frame_tick;
    logic        collide;
    logic [1:0]  state;
    logic [15:0] score_bcd;
    logic [15:0] hi_bcd;
    logic [2:0]  speed;
    logic        new_hi;

    int total;
    int bad;
    int pts;

    vec_t tab_b[8];
    vec_t tab_c[17];

    dino_score_ctrl #(
        .FRAMES_PER_POINT (6),
        .SPEEDUP_POINTS   (100)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .start      (start),
        .frame_tick (frame_tick),
        .collide    (collide),
        .state      (state),
        .score_bcd  (score_bcd),
        .hi_bcd     (hi_bcd),
        .speed      (speed),
        .new_hi     (new_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int n);
        int m;
        m = (n > 9999) ? 9999 : n;
        return {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    function automatic logic [2:0] exp_speed(input int n);
        int m;
        m = (n > 9999) ? 9999 : n;
        return (m / 100 > 7) ? 3'd7 : 3'(m / 100);
    endfunction

    function automatic vec_t mk(input logic e, input logic s, input logic f, input logic c,
                                input logic [1:0] st, input logic [15:0] sc,
                                input logic [15:0] hi, input logic [2:0] sp, input logic nh);
        vec_t v;
        v.ena = e; v.start = s; v.ft = f; v.col = c;
        v.st = st; v.sc = sc; v.hi = hi; v.sp = sp; v.nh = nh;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic e, input logic s, input logic f, input logic c);
        @(negedge clk);
        ena = e; start = s; frame_tick = f; collide = c;
        @(posedge clk);
        #1;
    endtask

    task automatic run_points(input int n);
        repeat (n * 6) cyc(1'b1, 1'b0, 1'b1, 1'b0);
        pts += n;
    endtask

    task automatic check_all(input string tag, input logic [1:0] st, input logic [15:0] sc,
                             input logic [15:0] hi, input logic [2:0] sp, input logic nh);
        chk({tag, ".state"}, 16'(state), 16'(st));
        chk({tag, ".score"}, score_bcd, sc);
        chk({tag, ".hi"}, hi_bcd, hi);
        chk({tag, ".speed"}, 16'(speed), 16'(sp));
        chk({tag, ".new_hi"}, 16'(new_hi), 16'(nh));
    endtask

    task automatic apply_vec(input string tag, input int idx, input vec_t v);
        cyc(v.ena, v.start, v.ft, v.col);
        check_all($sformatf("%s[%0d]", tag, idx), v.st, v.sc, v.hi, v.sp, v.nh);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        pts   = 0;

        // Game B tail: fcnt primed to 5 so a lone tick would score; collide must win
        for (int i = 0; i < 5; i++) tab_b[i] = mk(1, 0, 1, 0, 2'd1, 16'h0042, 16'h0000, 3'd0, 0);
        tab_b[5] = mk(1, 0, 1, 1, 2'd2, 16'h0042, 16'h0042, 3'd0, 1);
        tab_b[6] = mk(1, 0, 1, 1, 2'd2, 16'h0042, 16'h0042, 3'd0, 1);
        tab_b[7] = mk(1, 1, 0, 0, 2'd1, 16'h0000, 16'h0042, 3'd0, 0);

        // Game C tail: ena low across ticks/collide/start, then an equal-score finish
        for (int i = 0; i < 10; i++)
            tab_c[i] = mk(0, (i == 3), 1, (i % 4 == 1), 2'd1, 16'h0042, 16'h0042, 3'd0, 0);
        for (int i = 10; i < 15; i++) tab_c[i] = mk(1, 0, 1, 0, 2'd1, 16'h0042, 16'h0042, 3'd0, 0);
        tab_c[15] = mk(1, 0, 1, 1, 2'd2, 16'h0042, 16'h0042, 3'd0, 0);
        tab_c[16] = mk(1, 1, 0, 0, 2'd1, 16'h0000, 16'h0042, 3'd0, 0);

        rst_n = 1'b0; ena = 1'b0; start = 1'b0; frame_tick = 1'b0; collide = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all("reset", 2'd0, 16'h0000, 16'h0000, 3'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        cyc(1, 0, 1, 1);
        check_all("idle_ignore", 2'd0, 16'h0000, 16'h0000, 3'd0, 1'b0);

        // Game A: long run up to saturation
        cyc(1, 1, 0, 0);
        check_all("startA", 2'd1, 16'h0000, 16'h0000, 3'd0, 1'b0);
        repeat (11) cyc(1, 0, 1, 0);
        chk("tick11.score", score_bcd, 16'h0001);
        cyc(1, 0, 1, 0);
        pts = 2;
        chk("tick12.state", 16'(state), 16'd1);
        chk("tick12.score", score_bcd, 16'h0002);
        cyc(1, 1, 0, 0);
        check_all("start_in_run", 2'd1, 16'h0002, 16'h0000, 3'd0, 1'b0);

        run_points(7);
        check_all("pt9", 2'd1, to_bcd(pts), 16'h0000, exp_speed(pts), 1'b0);
        run_points(1);
        check_all("pt10", 2'd1, 16'h0010, 16'h0000, 3'd0, 1'b0);
        run_points(89);
        check_all("pt99", 2'd1, 16'h0099, 16'h0000, 3'd0, 1'b0);
        run_points(1);
        check_all("pt100", 2'd1, 16'h0100, 16'h0000, 3'd1, 1'b0);
        run_points(600);
        check_all("pt700", 2'd1, to_bcd(pts), 16'h0000, 3'd7, 1'b0);
        run_points(300);
        check_all("pt1000", 2'd1, 16'h1000, 16'h0000, 3'd7, 1'b0);
        run_points(8999);
        check_all("pt9999", 2'd1, 16'h9999, 16'h0000, 3'd7, 1'b0);
        run_points(30);
        check_all("sat", 2'd1, 16'h9999, 16'h0000, 3'd7, 1'b0);

        // Asynchronous reset between edges
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 2'd0, 16'h0000, 16'h0000, 3'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1, 0, 1, 1);
        check_all("post_rst_idle", 2'd0, 16'h0000, 16'h0000, 3'd0, 1'b0);

        // Game B: new high score
        cyc(1, 1, 0, 0);
        pts = 0;
        run_points(42);
        check_all("pt42B", 2'd1, 16'h0042, 16'h0000, 3'd0, 1'b0);
        for (int i = 0; i < 8; i++) apply_vec("tabB", i, tab_b[i]);

        // Game C: equal score, ena freeze
        run_points(42);
        check_all("pt42C", 2'd1, 16'h0042, 16'h0042, 3'd0, 1'b0);
        for (int i = 0; i < 17; i++) apply_vec("tabC", i, tab_c[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
